wiper_drive_seq: RTL and testbench

WIPER_DRIVE_SEQ -- requirements
Module: wiper_drive_seq

---
 rtl/wiper_pkg.sv | 30 +++
 rtl/wiper_tick_gen.sv | 33 +++
 rtl/wiper_drive_seq.sv | 129 ++++++++++++
 tb/tb_wiper_drive_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/wiper_pkg.sv
// ============================================================================
//  Module      : wiper_pkg
//  Description : Shared mode/state encodings and default geometry for the
//                wiper drive sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wiper_pkg;

    localparam int c_pos_max   = 8;
    localparam int c_dwell_cyc = 32;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        INTER = 2'b01,
        SLOW  = 2'b10,
        FAST  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        PARK  = 2'b00,
        OUT   = 2'b01,
        BACK  = 2'b10,
        DWELL = 2'b11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/wiper_tick_gen.sv
// ============================================================================
//  Module      : wiper_tick_gen
//  Description : Blade step divider; ticks every cycle in fast mode, every
//                second cycle otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wiper_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic fast,
    output logic tick
);

    logic r_phase;

    // Held cleared while the blade is idle, so the first slow tick of a
    // sweep lands on its second motor cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign tick = fast | r_phase;

endmodule

`default_nettype wire

// File: rtl/wiper_drive_seq.sv
// ============================================================================
//  Module      : wiper_drive_seq
//  Description : Wiper motor sequencer: park / outward / return / dwell with
//                position tracking and a completed-sweep counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wiper_drive_seq
    import wiper_pkg::*;
#(
    parameter int POS_MAX   = c_pos_max,
    parameter int DWELL_CYC = c_dwell_cyc
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       wiper,
    output logic                             motor_on,
    output logic                             motor_dir,
    output logic                             motor_fast,
    output logic                             parked,
    output logic [$clog2(POS_MAX+1)-1:0]     pos,
    output logic [7:0]                       sweep_cnt
);

    localparam int c_pw = $clog2(POS_MAX + 1);
    localparam int c_dw = $clog2(DWELL_CYC + 1);

    localparam logic [c_pw-1:0] c_pos_top   = c_pw'(POS_MAX);
    localparam logic [c_pw-1:0] c_pos_one   = c_pw'(1);
    localparam logic [c_dw-1:0] c_dwell_ld  = c_dw'(DWELL_CYC);
    localparam logic [c_dw-1:0] c_dwell_one = c_dw'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    mode_e             r_mode;
    mode_e             w_req;
    logic [c_pw-1:0]   r_pos;
    logic [c_pw-1:0]   w_pos_inc;
    logic [c_pw-1:0]   w_pos_dec;
    logic [c_dw-1:0]   r_dwell;
    logic [7:0]        r_sweep;
    logic              w_tick;
    logic              w_sweeping;

    assign w_req      = mode_e'(wiper);
    assign w_pos_inc  = r_pos + c_pos_one;
    assign w_pos_dec  = r_pos - c_pos_one;
    assign w_sweeping = (r_state == OUT) || (r_state == BACK);

    wiper_tick_gen u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (!w_sweeping),
        .fast  (r_mode == FAST),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PARK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PARK: begin
                if (w_req != OFF) w_state_nxt = OUT;
            end
            OUT: begin
                if (w_tick && (w_pos_inc == c_pos_top)) w_state_nxt = BACK;
            end
            BACK: begin
                if (w_tick && (w_pos_dec == '0)) begin
                    w_state_nxt = (r_mode == INTER) ? DWELL : PARK;
                end
            end
            DWELL: begin
                case (w_req)
                    OFF:     w_state_nxt = PARK;
                    INTER:   if (r_dwell == c_dwell_one) w_state_nxt = PARK;
                    default: w_state_nxt = OUT;
                endcase
            end
            default: w_state_nxt = PARK;
        endcase
    end

    // Mode is only sampled when a sweep is launched, so mid-sweep requests
    // cannot alter speed or stop the blade on the glass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= OFF;
            r_pos   <= '0;
            r_sweep <= '0;
            r_dwell <= '0;
        end else begin
            if ((r_state == PARK || r_state == DWELL) && w_state_nxt == OUT) begin
                r_mode <= w_req;
            end
            if (r_state == OUT && w_tick) begin
                r_pos <= w_pos_inc;
            end else if (r_state == BACK && w_tick) begin
                r_pos <= w_pos_dec;
                if (w_pos_dec == '0) r_sweep <= r_sweep + 8'd1;
            end
            if (r_state != DWELL && w_state_nxt == DWELL) begin
                r_dwell <= c_dwell_ld;
            end else if (r_state == DWELL && r_dwell != '0) begin
                r_dwell <= r_dwell - c_dwell_one;
            end
        end
    end

    always_comb begin
        motor_on   = w_sweeping;
        motor_dir  = (r_state == OUT);
        motor_fast = w_sweeping && (r_mode == FAST);
        parked     = (r_state == PARK) || (r_state == DWELL);
        pos        = r_pos;
        sweep_cnt  = r_sweep;
    end

endmodule

`default_nettype wire

// File: tb/tb_wiper_drive_seq.sv
// ============================================================================
//  Module      : tb_wiper_drive_seq
//  Description : Self-checking bench for wiper_drive_seq (default geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wiper_drive_seq;

    typedef struct packed {
        logic       on;
        logic       dir;
        logic       fast;
        logic       parked;
        logic [3:0] pos;
        logic [7:0] sw;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [1:0] wiper;
        int         n;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] wiper = 2'b00;
    logic       motor_on;
    logic       motor_dir;
    logic       motor_fast;
    logic       parked;
    logic [3:0] pos;
    logic [7:0] sweep_cnt;

    vec_t  vecs[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    wiper_drive_seq dut (
        .clk        (clk),
        .reset      (reset),
        .wiper      (wiper),
        .motor_on   (motor_on),
        .motor_dir  (motor_dir),
        .motor_fast (motor_fast),
        .parked     (parked),
        .pos        (pos),
        .sweep_cnt  (sweep_cnt)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic on, input logic dir, input logic fast,
                                 input logic pk, input int p, input int s);
        outs_t o;
        o.on     = on;
        o.dir    = dir;
        o.fast   = fast;
        o.parked = pk;
        o.pos    = 4'(p);
        o.sw     = 8'(s);
        return o;
    endfunction

    task automatic add(input logic r, input logic [1:0] w, input int n,
                       input logic on, input logic dir, input logic fast,
                       input logic pk, input int p, input int s);
        vec_t v;
        v.rst   = r;
        v.wiper = w;
        v.n     = n;
        v.exp   = mk(on, dir, fast, pk, p, s);
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name);
        outs_t a;
        outs_t e;
        a = {motor_on, motor_dir, motor_fast, parked, pos, sweep_cnt};
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got on=%0b dir=%0b fast=%0b parked=%0b pos=%0d sweep=%0d, expected on=%0b dir=%0b fast=%0b parked=%0b pos=%0d sweep=%0d",
                     name, a.on, a.dir, a.fast, a.parked, a.pos, a.sw,
                     e.on, e.dir, e.fast, e.parked, e.pos, e.sw);
        end
    endtask

    // Drive inputs, queue the expected outputs, advance n edges, then compare.
    task automatic apply(input logic r, input logic [1:0] w, input int n,
                         input outs_t e, input string name);
        reset = r;
        wiper = w;
        exp_q.push_back(e);
        repeat (n) @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        //   rst wiper  n   on dir fst pk pos sw
        add(1, 2'b00,  2,  0, 0, 0, 1, 0, 0);   // reset state
        add(0, 2'b11,  1,  1, 1, 1, 0, 0, 0);   // fast request -> OUT next cycle
        add(0, 2'b11,  7,  1, 1, 1, 0, 7, 0);
        add(0, 2'b11,  1,  1, 0, 1, 0, 8, 0);   // reaches top, turns back
        add(0, 2'b11,  7,  1, 0, 1, 0, 1, 0);
        add(0, 2'b11,  1,  0, 0, 0, 1, 0, 1);   // one PARK cycle between sweeps
        add(0, 2'b11,  1,  1, 1, 1, 0, 0, 1);   // next sweep 17 cycles later
        add(0, 2'b10,  4,  1, 1, 1, 0, 4, 1);   // mode change ignored mid-sweep
        add(0, 2'b00,  4,  1, 0, 1, 0, 8, 1);
        add(0, 2'b00,  8,  0, 0, 0, 1, 0, 2);
        add(0, 2'b00,  3,  0, 0, 0, 1, 0, 2);   // off stays parked
        add(0, 2'b10,  1,  1, 1, 0, 0, 0, 2);   // slow
        add(0, 2'b10,  1,  1, 1, 0, 0, 0, 2);   // no tick on first OUT cycle
        add(0, 2'b10,  1,  1, 1, 0, 0, 1, 2);
        add(0, 2'b10,  2,  1, 1, 0, 0, 2, 2);
        add(0, 2'b10, 12,  1, 0, 0, 0, 8, 2);
        add(0, 2'b00, 15,  1, 0, 0, 0, 1, 2);
        add(0, 2'b00,  1,  0, 0, 0, 1, 0, 3);   // 32 motor cycles total
        add(0, 2'b01,  1,  1, 1, 0, 0, 0, 3);   // intermittent
        add(0, 2'b01, 32,  0, 0, 0, 1, 0, 4);   // into DWELL
        add(0, 2'b01, 31,  0, 0, 0, 1, 0, 4);
        add(0, 2'b01,  1,  0, 0, 0, 1, 0, 4);   // DWELL expires to PARK
        add(0, 2'b01,  1,  1, 1, 0, 0, 0, 4);   // 65-cycle intermittent period
        add(0, 2'b01, 32,  0, 0, 0, 1, 0, 5);
        add(0, 2'b01,  5,  0, 0, 0, 1, 0, 5);
        add(0, 2'b11,  1,  1, 1, 1, 0, 0, 5);   // fast from DWELL -> OUT next cycle
        add(0, 2'b11, 16,  0, 0, 0, 1, 0, 6);
        add(0, 2'b01,  1,  1, 1, 0, 0, 0, 6);
        add(0, 2'b01, 32,  0, 0, 0, 1, 0, 7);
        add(0, 2'b00,  1,  0, 0, 0, 1, 0, 7);   // off in DWELL -> PARK
        add(0, 2'b00, 40,  0, 0, 0, 1, 0, 7);
        add(0, 2'b11,  1,  1, 1, 1, 0, 0, 7);
        add(0, 2'b11,  5,  1, 1, 1, 0, 5, 7);
        add(0, 2'b00,  3,  1, 0, 1, 0, 8, 7);   // off at pos 5 completes sweep
        add(0, 2'b00,  8,  0, 0, 0, 1, 0, 8);
        add(0, 2'b00,  5,  0, 0, 0, 1, 0, 8);
        add(0, 2'b11,  7,  1, 1, 1, 0, 6, 8);
        add(1, 2'b11,  1,  0, 0, 0, 1, 0, 0);   // reset mid-sweep at pos 6
        add(1, 2'b11,  3,  0, 0, 0, 1, 0, 0);
        add(0, 2'b11,  1,  1, 1, 1, 0, 0, 0);   // first edge after reset acts as PARK
        add(0, 2'b00, 16,  0, 0, 0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].wiper, vecs[i].n, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Sweep counter wrap: fast sweeps complete every 17 edges.
        apply(1'b1, 2'b00, 2,        mk(0, 0, 0, 1, 0, 0),   "wrap_reset");
        apply(1'b0, 2'b11, 17 * 255, mk(0, 0, 0, 1, 0, 255), "wrap255");
        apply(1'b0, 2'b11, 1,        mk(1, 1, 1, 0, 0, 255), "wrap_relaunch");
        apply(1'b0, 2'b11, 16,       mk(0, 0, 0, 1, 0, 0),   "wrap0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
